// File: rtl/ets_phase_sweeper.sv
// Equivalent-time-sampling sweep controller: per phase step it accumulates comparator hits, writes one result word,
// then performs one MMCM phase-shift handshake. Optional macro ETS_PS_TIMEOUT_EN adds a WAIT_PS watchdog and ps_timeout.
`timescale 1ns/1ps
module ets_phase_sweeper #(
    parameter int NUM_CH        = 4,
    parameter int ACC_WIDTH     = 16,
    parameter int ADDR_WIDTH    = 9,
    parameter int PHASE_STEPS   = 448,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [ACC_WIDTH-1:0]          avg_count,
    input  logic                          trigger,
    input  logic [NUM_CH-1:0]             cmp_data,
    output logic                          ps_en,
    output logic                          ps_incdec,
    input  logic                          ps_done,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [NUM_CH*ACC_WIDTH-1:0]   wr_data,
    output logic [31:0]                   phase_counter,
    output logic                          busy,
    output logic                          sweep_done
`ifdef ETS_PS_TIMEOUT_EN
    ,
    output logic                          ps_timeout
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACC     = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] SHIFT   = 3'd3;
    localparam logic [2:0] WAIT_PS = 3'd4;
    localparam logic [2:0] SETTLE  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
`ifdef ETS_PS_TIMEOUT_EN
    localparam logic [2:0] ERR     = 3'd7;
`endif

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [2:0]                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]             phase_q, phase_d;
    logic [NUM_CH*ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [ACC_WIDTH-1:0]              trig_cnt_q, trig_cnt_d;
    logic [ACC_WIDTH-1:0]              target_q, target_d;
    logic [SW-1:0]                     settle_cnt_q, settle_cnt_d;
    logic                              trigger_d_q, trigger_d_d;
    logic                              ps_incdec_q, ps_incdec_d;
    logic                              trig_event;
    logic [ACC_WIDTH-1:0]              avg_target;
`ifdef ETS_PS_TIMEOUT_EN
    logic [15:0]                       wd_q, wd_d;
`endif

    function automatic logic [ACC_WIDTH-1:0] sat_inc(input logic [ACC_WIDTH-1:0] a, input logic hit);
        if (hit && (a != {ACC_WIDTH{1'b1}}))
            return a + 1'b1;
        return a;
    endfunction

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        acc_d        = acc_q;
        trig_cnt_d   = trig_cnt_q;
        target_d     = target_q;
        settle_cnt_d = '0;
        trigger_d_d  = trigger;
        ps_incdec_d  = 1'b1;
        trig_event   = trigger && !trigger_d_q;
        avg_target   = (avg_count == '0) ? {{(ACC_WIDTH-1){1'b0}}, 1'b1} : avg_count;
`ifdef ETS_PS_TIMEOUT_EN
        wd_d         = '0;
`endif
        case (state_q)
            IDLE: begin
                acc_d      = '0;
                trig_cnt_d = '0;
                if (en) begin
                    state_d  = ACC;
                    target_d = avg_target;
                end
            end
            ACC: begin
                if (!en) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    trig_cnt_d = '0;
                end else if (trig_cnt_q == target_q) begin
                    state_d = WRITE;
                end else if (trig_event) begin
                    for (int c = 0; c < NUM_CH; c++)
                        acc_d[c*ACC_WIDTH +: ACC_WIDTH] = sat_inc(acc_q[c*ACC_WIDTH +: ACC_WIDTH], cmp_data[c]);
                    trig_cnt_d = trig_cnt_q + 1'b1;
                end
            end
            WRITE: begin
                // Result is presented this cycle; the accumulators restart from zero afterwards.
                acc_d      = '0;
                trig_cnt_d = '0;
                state_d    = (phase_q == ADDR_WIDTH'(PHASE_STEPS - 1)) ? DONE : SHIFT;
            end
            SHIFT: begin
                state_d = WAIT_PS;
            end
            WAIT_PS: begin
                if (ps_done) begin
                    state_d = en ? SETTLE : IDLE;
                end
`ifdef ETS_PS_TIMEOUT_EN
                else if (wd_q == 16'hFFFE) begin
                    state_d = ERR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            SETTLE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d  = ACC;
                    phase_d  = phase_q + 1'b1;
                    target_d = avg_target;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            end
`ifdef ETS_PS_TIMEOUT_EN
            ERR: begin
                state_d = ERR;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            acc_q        <= '0;
            trig_cnt_q   <= '0;
            target_q     <= '0;
            settle_cnt_q <= '0;
            trigger_d_q  <= 1'b0;
            ps_incdec_q  <= 1'b0;
`ifdef ETS_PS_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            trig_cnt_q   <= trig_cnt_d;
            target_q     <= target_d;
            settle_cnt_q <= settle_cnt_d;
            trigger_d_q  <= trigger_d_d;
            ps_incdec_q  <= ps_incdec_d;
`ifdef ETS_PS_TIMEOUT_EN
            wd_q         <= wd_d;
`endif
        end
    end

    assign wr_en         = (state_q == WRITE);
    assign ps_en         = (state_q == SHIFT);
    assign ps_incdec     = ps_incdec_q;
    assign wr_addr       = phase_q;
    assign wr_data       = acc_q;
    assign phase_counter = 32'(phase_q);
    assign sweep_done    = (state_q == DONE);
`ifdef ETS_PS_TIMEOUT_EN
    assign ps_timeout    = (state_q == ERR);
    assign busy          = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
`else
    assign busy          = (state_q != IDLE) && (state_q != DONE);
`endif

endmodule

// File: tb/tb_ets_phase_sweeper.sv
// Scoreboard bench for ets_phase_sweeper: stimulus pushes expected result words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ets_phase_sweeper;

    localparam int NCH = 4;
    localparam int AW  = 4;
    localparam int ADW = 3;
    localparam int PS  = 4;
    localparam int SC  = 3;

    logic clk = 1'b0;
    logic reset, en, trigger, ps_done;
    logic [AW-1:0] avg_count;
    logic [NCH-1:0] cmp_data;
    logic ps_en, ps_incdec, wr_en, busy, sweep_done;
    logic [ADW-1:0] wr_addr;
    logic [NCH*AW-1:0] wr_data;
    logic [31:0] phase_counter;
`ifdef ETS_PS_TIMEOUT_EN
    logic ps_timeout;
`endif

    ets_phase_sweeper #(
        .NUM_CH(NCH), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .PHASE_STEPS(PS), .SETTLE_CYCLES(SC)
    ) dut (
        .sys_clk(clk), .reset(reset), .en(en), .avg_count(avg_count), .trigger(trigger),
        .cmp_data(cmp_data), .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .phase_counter(phase_counter),
        .busy(busy), .sweep_done(sweep_done)
`ifdef ETS_PS_TIMEOUT_EN
        , .ps_timeout(ps_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADW-1:0]    addr;
        logic [NCH*AW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_fail = 0;
    int ps_seen = 0;
    int exp_ps = 0;
    logic prev_wr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the oldest expectation; every shift must follow a write.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(wr_data), 64'(mon_e.data));
            end
        end
        if (ps_en) begin
            ps_seen++;
            check("ps_en_after_wr", 64'(prev_wr), 64'd1);
            check("ps_incdec", 64'(ps_incdec), 64'd1);
        end
        prev_wr = wr_en;
    end

    // One phase step: target = max(avg_now,1) trigger edges; expected hits are plain per-channel counts.
    task automatic run_step(input logic [ADW-1:0] addr, input logic [AW-1:0] avg_now,
                            input logic [AW-1:0] avg_next, input bit fixed, input logic [NCH-1:0] cmp_fix);
        int tgt;
        int hits[NCH];
        exp_t e;
        logic [NCH-1:0] v;
        tgt = (avg_now == 0) ? 1 : int'(avg_now);
        for (int c = 0; c < NCH; c++) hits[c] = 0;
        for (int k = 0; k < tgt; k++) begin
            v = fixed ? cmp_fix : NCH'($urandom);
            cmp_data = v;
            trigger = 1'b1;
            tick();
            trigger = 1'b0;
            cmp_data = NCH'($urandom);
            if (k == 0) avg_count = avg_next;
            for (int c = 0; c < NCH; c++)
                if (v[c]) hits[c] = (hits[c] + 1 > (1 << AW) - 1) ? (1 << AW) - 1 : hits[c] + 1;
            tick();
        end
        e.addr = addr;
        for (int c = 0; c < NCH; c++) e.data[c*AW +: AW] = AW'(hits[c]);
        exp_q.push_back(e);
    endtask

    task automatic wait_ps_en();
        int n;
        n = 0;
        while (!ps_en && n < 30) begin
            tick();
            n++;
        end
        check("ps_en_seen", 64'(ps_en), 64'd1);
        exp_ps++;
    endtask

    task automatic finish_shift(input int d);
        for (int i = 0; i < d; i++) begin
            trigger = 1'($urandom);
            cmp_data = NCH'($urandom);
            tick();
        end
        trigger = 1'b0;
        ps_done = 1'b1;
        tick();
        ps_done = 1'b0;
        repeat (SC + 1) tick();
    endtask

    task automatic done_checks();
        tick();
        tick();
        check("sweep_done", 64'(sweep_done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("phase_done", 64'(phase_counter), 64'(PS - 1));
        check("ps_en_count", 64'(ps_seen), 64'(exp_ps));
    endtask

    task automatic rand_sweep_from(input int start_p, input logic [AW-1:0] avg_start);
        logic [AW-1:0] avg_now, nxt;
        avg_now = avg_start;
        for (int p = start_p; p < PS; p++) begin
            nxt = AW'($urandom);
            run_step(ADW'(p), avg_now, nxt, 1'b0, '0);
            if (p < PS - 1) begin
                wait_ps_en();
                finish_shift(int'($urandom_range(1, 5)));
            end
            avg_now = nxt;
        end
        done_checks();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; avg_count = '0; trigger = 1'b0; cmp_data = '0; ps_done = 1'b0;
        repeat (3) tick();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_ps_en", 64'(ps_en), 64'd0);
        check("rst_ps_incdec", 64'(ps_incdec), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sweep_done", 64'(sweep_done), 64'd0);
        check("rst_phase", 64'(phase_counter), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);

        // Directed sweep: fixed pattern, avg 0 -> 1 trigger, avg 20 truncated to 4, full-scale 15
        reset = 1'b0; avg_count = 4'd4; en = 1'b1;
        tick(); tick();
        check("busy_acc", 64'(busy), 64'd1);
        run_step(3'd0, 4'd4, 4'd0, 1'b1, 4'b0101);
        wait_ps_en(); finish_shift(3);
        run_step(3'd1, 4'd0, 4'(20), 1'b1, 4'b0001);
        wait_ps_en(); finish_shift(2);
        run_step(3'd2, 4'(20), 4'd15, 1'b1, 4'b0001);
        wait_ps_en(); finish_shift(1);
        run_step(3'd3, 4'd15, 4'd5, 1'b1, 4'hF);
        done_checks();
        en = 1'b0;
        tick(); tick();
        check("idle_sweep_done", 64'(sweep_done), 64'd0);
        check("idle_phase_clr", 64'(phase_counter), 64'd0);

        // Reset during accumulation discards partial hits
        avg_count = 4'd8; en = 1'b1;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            cmp_data = 4'hF; trigger = 1'b1; tick(); trigger = 1'b0; tick();
        end
        reset = 1'b1; avg_count = 4'd3;
        tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_wr_data", 64'(wr_data), 64'd0);
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_phase", 64'(phase_counter), 64'd0);
        reset = 1'b0;
        tick(); tick();
        run_step(3'd0, 4'd3, 4'd9, 1'b0, '0);

        // en dropped during the handshake: shift completes, then idle with phase held
        wait_ps_en();
        en = 1'b0;
        repeat (5) tick();
        ps_done = 1'b1; tick(); ps_done = 1'b0;
        repeat (4) tick();
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_phase", 64'(phase_counter), 64'd0);
        check("drop_ps_count", 64'(ps_seen), 64'(exp_ps));
        ps_done = 1'b1; tick(); ps_done = 1'b0; tick();
        check("stray_done_busy", 64'(busy), 64'd0);
        en = 1'b1;
        tick(); tick();
        run_step(3'd0, 4'd9, 4'd2, 1'b0, '0);

        // ps_done in the same cycle as ps_en must be ignored; later edges must then be discarded
        wait_ps_en();
        ps_done = 1'b1; tick(); ps_done = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            cmp_data = 4'hF; trigger = 1'b1; tick(); trigger = 1'b0; tick();
        end
        finish_shift(2);
        rand_sweep_from(1, 4'd2);

        for (int s = 0; s < 2; s++) begin
            logic [AW-1:0] a;
            en = 1'b0;
            tick(); tick();
            check("rand_idle_done", 64'(sweep_done), 64'd0);
            a = AW'($urandom);
            avg_count = a;
            en = 1'b1;
            tick(); tick();
            rand_sweep_from(0, a);
        end

        check("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
